instr_fetch_queue: RTL and testbench
====================================

INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, sets queue entries; SHALL be a power of two, 2..16.
REQ-002 Parameter RESET_PC, default 32'h00001000, sets the PC value loaded by reset.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 startSel  input  1  when high, loads startAddress into PC and flushes the queue.
REQ-006 startAddress  input  32  PC load value used with startSel.
REQ-007 redirect  input  1  branch/jump redirect from the pipeline; flushes the queue.
REQ-008 redirectAddr  input  32  redirect target.
REQ-009 imemAddr  output  32  fetch address to combinational instruction memory; SHALL equal current PC.
REQ-010 imemData  input  32  instruction word returned combinationally for imemAddr.
REQ-011 instOut  output  32  instruction at queue head.
REQ-012 pcOut  output  32  fetch address of the queue-head instruction.
REQ-013 instValid  output  1  queue head holds a valid entry.
REQ-014 deqReady  input  1  decode accepts head; a dequeue occurs when instValid && deqReady.
REQ-015 count  output  $clog2(DEPTH)+1  current number of entries.

Function
REQ-016 Each queue entry SHALL store {pc, instruction}; storage is a circular buffer with read/write pointers modulo DEPTH.
REQ-017 Control priority SHALL be: reset > startSel > redirect > normal operation.
REQ-018 Normal operation: push SHALL occur when count < DEPTH, or count == DEPTH with a dequeue in the same cycle; a push writes {PC, imemData} and sets PC <= PC + 4.
REQ-019 When no push occurs, PC SHALL hold.
REQ-020 PC arithmetic SHALL be modulo 2^32; 32'hFFFFFFFC + 4 wraps to 32'h00000000.
REQ-021 Simultaneous push and dequeue SHALL leave count unchanged and advance both pointers.
REQ-022 Dequeue SHALL be ignored when instValid is low (empty); count never underflows.
REQ-023 Push SHALL never occur when full without a same-cycle dequeue; count never exceeds DEPTH.
REQ-024 startSel high: PC <= {startAddress[31:2], 2'b00}, count <= 0, pointers <= 0; no push and no dequeue that cycle.
REQ-025 redirect high (startSel low): PC <= {redirectAddr[31:2], 2'b00}; queue flushed as in REQ-024; no push; a concurrent dequeue is discarded.
REQ-026 Latency: after startSel or redirect at edge N, the target is fetched during cycle N+1, and instValid is high with pcOut equal to the target after edge N+1 (if not reset).
REQ-027 instOut, pcOut and instValid SHALL be driven from stored state and count only; they SHALL have no combinational path from imemData, deqReady or redirect.
REQ-028 When instValid is low, instOut and pcOut SHALL be 32'h00000000.
REQ-029 imemAddr SHALL equal the PC register at all times, including during stalls.

Reset
REQ-030 reset high at an edge: PC <= RESET_PC, count <= 0, pointers <= 0; instValid, instOut and pcOut read 0 from the next cycle.
REQ-031 reset asserted mid-operation SHALL discard all queued entries, and any same-cycle push, dequeue, startSel or redirect.
REQ-032 First push after reset release SHALL fetch address RESET_PC.

Verification
REQ-033 Reset, then startSel=1 with startAddress=32'h00001000 for one cycle, deqReady=0 -> after 4 push cycles count=4, PC=32'h00001010, imemAddr holds 32'h00001010, no further push.
REQ-034 Full queue, deqReady=1 continuously -> one dequeue and one push per cycle; pcOut sequence 1000, 1004, 1008, ...; count stays 4.
REQ-035 redirect=1, redirectAddr=32'h00002003, with 3 entries queued and deqReady=1 -> next cycle count=0, instValid=0, imemAddr=32'h00002000; the cycle after, pcOut=32'h00002000 and instValid=1.
REQ-036 startSel=1 and redirect=1 in the same cycle, startAddress=32'h00003000, redirectAddr=32'h00004000 -> PC=32'h00003000.
REQ-037 startAddress=32'hFFFFFFF8, deqReady=1 -> pcOut sequence FFFFFFF8, FFFFFFFC, 00000000.
REQ-038 reset asserted while count=2 and redirect=1 -> next cycle count=0, PC=RESET_PC, instValid=0.

Source files
------------

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: fetches sequential instructions from a combinational imem
// into a circular {pc, inst} queue, with start/redirect flush control.
module instr_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_1000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       startSel,
    input  logic [31:0]                startAddress,
    input  logic                       redirect,
    input  logic [31:0]                redirectAddr,
    output logic [31:0]                imemAddr,
    input  logic [31:0]                imemData,
    output logic [31:0]                instOut,
    output logic [31:0]                pcOut,
    output logic                       instValid,
    input  logic                       deqReady,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [31:0]   pc_mem_q [DEPTH];
    logic [31:0]   inst_mem_q [DEPTH];
    logic [31:0]   pc_q, pc_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          flush, push, deq;

    assign flush = startSel || redirect;
    assign deq   = instValid && deqReady && !flush;
    // A full queue may still accept a push when its head leaves the same cycle.
    assign push  = !flush && ((count_q != FULL) || deq);

    always_comb begin
        pc_d     = pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            pc_d     = startSel ? {startAddress[31:2], 2'b00} : {redirectAddr[31:2], 2'b00};
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            pc_d     = push ? pc_q + 32'd4 : pc_q;
            wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
            rd_ptr_d = deq ? rd_ptr_q + AW'(1) : rd_ptr_q;
            count_d  = count_q + CW'(push) - CW'(deq);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            pc_mem_q[wr_ptr_q]   <= pc_q;
            inst_mem_q[wr_ptr_q] <= imemData;
        end
    end

    assign imemAddr  = pc_q;
    assign count     = count_q;
    assign instValid = count_q != '0;
    assign instOut   = instValid ? inst_mem_q[rd_ptr_q] : 32'h0;
    assign pcOut     = instValid ? pc_mem_q[rd_ptr_q] : 32'h0;
endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue: directed vectors for instr_fetch_queue with a
// synthetic imem whose word is derived from its address.
module tb_instr_fetch_queue;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        startSel = 1'b0;
    logic [31:0] startAddress = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirectAddr = '0;
    logic [31:0] imemAddr, imemData, instOut, pcOut;
    logic        instValid;
    logic        deqReady = 1'b0;
    logic [2:0]  count;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    assign imemData = word_at(imemAddr);

    instr_fetch_queue dut (
        .clk(clk), .reset(reset), .startSel(startSel), .startAddress(startAddress),
        .redirect(redirect), .redirectAddr(redirectAddr), .imemAddr(imemAddr),
        .imemData(imemData), .instOut(instOut), .pcOut(pcOut), .instValid(instValid),
        .deqReady(deqReady), .count(count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic head(input string tag, input logic [31:0] pc, input logic [2:0] cnt);
        chk({tag, "_pc"}, pcOut, pc);
        chk({tag, "_inst"}, instOut, word_at(pc));
        chk({tag, "_valid"}, {31'b0, instValid}, 32'd1);
        chk({tag, "_count"}, {29'b0, count}, {29'b0, cnt});
    endtask

    task automatic empty(input string tag);
        chk({tag, "_count"}, {29'b0, count}, 32'd0);
        chk({tag, "_valid"}, {31'b0, instValid}, 32'd0);
        chk({tag, "_pc"}, pcOut, 32'h0);
        chk({tag, "_inst"}, instOut, 32'h0);
    endtask

    initial begin
        tick();
        empty("reset");
        chk("reset_addr", imemAddr, 32'h0000_1000);
        reset = 1'b0;
        startSel = 1'b1;
        startAddress = 32'h0000_1000;
        tick();
        startSel = 1'b0;
        empty("start");
        chk("start_addr", imemAddr, 32'h0000_1000);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("fill_count", {29'b0, count}, i);
        end
        head("full", 32'h0000_1000, 3'd4);
        chk("full_addr", imemAddr, 32'h0000_1010);
        tick();
        chk("stall_count", {29'b0, count}, 32'd4);
        chk("stall_addr", imemAddr, 32'h0000_1010);
        deqReady = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            head("stream", 32'h0000_1000 + 4 * i, 3'd4);
            chk("stream_addr", imemAddr, 32'h0000_1010 + 4 * i);
        end
        deqReady = 1'b0;
        startSel = 1'b1;
        tick();
        startSel = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("three_count", {29'b0, count}, 32'd3);
        redirect = 1'b1;
        redirectAddr = 32'h0000_2003;
        deqReady = 1'b1;
        tick();
        redirect = 1'b0;
        deqReady = 1'b0;
        empty("redir");
        chk("redir_addr", imemAddr, 32'h0000_2000);
        tick();
        head("redir_tgt", 32'h0000_2000, 3'd1);
        startSel = 1'b1;
        startAddress = 32'h0000_3000;
        redirect = 1'b1;
        redirectAddr = 32'h0000_4000;
        tick();
        startSel = 1'b0;
        redirect = 1'b0;
        chk("prio_addr", imemAddr, 32'h0000_3000);
        chk("prio_count", {29'b0, count}, 32'd0);
        startSel = 1'b1;
        startAddress = 32'hFFFF_FFF8;
        tick();
        startSel = 1'b0;
        deqReady = 1'b1;
        tick();
        head("wrap0", 32'hFFFF_FFF8, 3'd1);
        tick();
        head("wrap1", 32'hFFFF_FFFC, 3'd1);
        tick();
        head("wrap2", 32'h0000_0000, 3'd1);
        chk("wrap_addr", imemAddr, 32'h0000_0004);
        deqReady = 1'b0;
        startSel = 1'b1;
        startAddress = 32'h0000_5000;
        tick();
        startSel = 1'b0;
        tick();
        tick();
        chk("pre_rst_count", {29'b0, count}, 32'd2);
        reset = 1'b1;
        redirect = 1'b1;
        redirectAddr = 32'h0000_4000;
        tick();
        reset = 1'b0;
        redirect = 1'b0;
        empty("mid_rst");
        chk("mid_rst_addr", imemAddr, 32'h0000_1000);
        tick();
        head("post_rst", 32'h0000_1000, 3'd1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
